scan_sequencer: RTL and testbench

Free-running channel scanner that drives the 2-bit select inputs `a`/`b` of the team's 2-to-4 decoder, stepping through the enabled subset of its four output lines. Each channel is held for a programmable dwell, separated by an optional blanking gap. Typical use is multiplexed display digits or time-sliced enables. A `blank` output lets downstream logic gate the decoder outputs during gaps and idle.

---
 rtl/scan_pkg.sv | 22 ++
 rtl/rr_next.sv | 26 ++
 rtl/scan_sequencer.sv | 130 +++++++++++++
 tb/tb_scan_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and helpers for the channel scanner: FSM state encoding,
// channel-to-decoder-select mapping and the scan-pass wrap test.
package scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Channel index as seen on {b,a}; the name is the decoder line it drives.
    localparam logic [1:0] CH_D4 = 2'd0;
    localparam logic [1:0] CH_D3 = 2'd1;
    localparam logic [1:0] CH_D2 = 2'd2;
    localparam logic [1:0] CH_D1 = 2'd3;

    // A new pass starts whenever the scan does not move to a higher index.
    function automatic logic wrap_detect(input logic [1:0] prev, input logic [1:0] next);
        return (next <= prev);
    endfunction

endpackage

// File: rtl/rr_next.sv
// Combinational round-robin search: first enabled channel strictly after
// cur_i, wrapping 3->0; a single enabled channel finds itself.
module rr_next (
    input  logic [1:0] cur_i,
    input  logic [3:0] mask_i,
    output logic [1:0] next_o,
    output logic       none_o
);

    logic [1:0] idx;

    // Scan from the farthest offset to the nearest so the nearest hit wins.
    always_comb begin
        next_o = cur_i;
        none_o = 1'b1;
        idx    = cur_i;
        for (int k = 4; k >= 1; k--) begin
            idx = cur_i + 2'(k);
            if (mask_i[idx]) begin
                next_o = idx;
                none_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/scan_sequencer.sv
// Free-running scanner driving the a/b selects of a 2-to-4 decoder through
// the enabled channels, with a programmable dwell and optional blanking gap.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int GAP   = 1,
    parameter int CW    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] ch_mask,
    output logic       a,
    output logic       b,
    output logic       blank,
    output logic       busy,
    output logic       wrap
);

    localparam logic          HAS_GAP    = (GAP > 0);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'((GAP > 0) ? GAP - 1 : 0);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    chan_q, chan_d;
    logic          stopPend_q, stopPend_d;
    logic          wrap_q, wrap_d;
    logic          blank_q, busy_q;

    logic [1:0]    rrCur;
    logic [1:0]    rrNext;
    logic          rrNone;

    // From IDLE the search origin is the last channel, so the result is the lowest set bit.
    assign rrCur = (state_q == ST_IDLE) ? CH_D1 : chan_q;

    rr_next u_rr_next (
        .cur_i  (rrCur),
        .mask_i (ch_mask),
        .next_o (rrNext),
        .none_o (rrNone)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        chan_d     = chan_q;
        stopPend_d = stopPend_q;
        wrap_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stopPend_d = 1'b0;
                cnt_d      = '0;
                if (start && !stop && !rrNone) begin
                    state_d = ST_DWELL;
                    chan_d  = rrNext;
                end
            end
            ST_DWELL: begin
                stopPend_d = stopPend_q | stop;
                if (cnt_q == DWELL_LAST) begin
                    cnt_d = '0;
                    if (stopPend_d || rrNone) begin
                        state_d    = ST_IDLE;
                        stopPend_d = 1'b0;
                    end else if (HAS_GAP) begin
                        state_d = ST_GAP;
                    end else begin
                        chan_d = rrNext;
                        wrap_d = wrap_detect(chan_q, rrNext);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_GAP: begin
                // A stop seen here is held until the following dwell has run.
                stopPend_d = stopPend_q | stop;
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (rrNone) begin
                        state_d    = ST_IDLE;
                        stopPend_d = 1'b0;
                    end else begin
                        state_d = ST_DWELL;
                        chan_d  = rrNext;
                        wrap_d  = wrap_detect(chan_q, rrNext);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // blank/busy are registered from the next state so they line up with a/b.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            chan_q     <= CH_D4;
            stopPend_q <= 1'b0;
            wrap_q     <= 1'b0;
            blank_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            chan_q     <= chan_d;
            stopPend_q <= stopPend_d;
            wrap_q     <= wrap_d;
            blank_q    <= (state_d != ST_DWELL);
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign a     = chan_q[0];
    assign b     = chan_q[1];
    assign blank = blank_q;
    assign busy  = busy_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench: two scanners (default gap and zero gap) compared every
// cycle against a countdown model of the scan rules, plus literal checkpoints.
module tb_scan_sequencer;

    localparam int D0 = 4;
    localparam int G0 = 1;
    localparam int D1 = 4;
    localparam int G1 = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start0, stop0, start1, stop1;
    logic [3:0] mask0, mask1;
    logic       a0, b0, blank0, busy0, wrap0;
    logic       a1, b1, blank1, busy1, wrap1;

    int tests = 0;
    int fails = 0;

    scan_sequencer #(.DWELL(D0), .GAP(G0), .CW(8)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .stop(stop0), .ch_mask(mask0),
        .a(a0), .b(b0), .blank(blank0), .busy(busy0), .wrap(wrap0)
    );

    scan_sequencer #(.DWELL(D1), .GAP(G1), .CW(8)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .stop(stop1), .ch_mask(mask1),
        .a(a1), .b(b1), .blank(blank1), .busy(busy1), .wrap(wrap1)
    );

    // phase: 0 idle, 1 showing a channel, 2 blank gap; left counts cycles remaining.
    typedef struct packed {
        logic [1:0]  phase;
        logic [15:0] left;
        logic [1:0]  ch;
        logic        pend;
        logic        wrap;
    } model_t;

    model_t mod0 = '0;
    model_t mod1 = '0;
    logic   modValid = 1'b0;

    function automatic int lowestCh(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return -1;
    endfunction

    function automatic int nextCh(input int cur, input logic [3:0] m);
        for (int k = 1; k <= 4; k++) if (m[(cur + k) % 4]) return (cur + k) % 4;
        return -1;
    endfunction

    function automatic model_t stepModel(input model_t m, input logic r, input logic s,
                                         input logic p, input logic [3:0] mk,
                                         input int dwell, input int gap);
        model_t n;
        int nc;
        n = m;
        if (r) return '0;
        n.wrap = 1'b0;
        if (m.phase == 2'd0) begin
            if (s && !p && mk != 4'd0) begin
                n.phase = 2'd1;
                n.left  = 16'(dwell);
                n.ch    = 2'(lowestCh(mk));
            end
        end else begin
            n.pend = m.pend | p;
            n.left = m.left - 16'd1;
            if (n.left == 16'd0) begin
                if (m.phase == 2'd1 && (n.pend || mk == 4'd0)) begin
                    n.phase = 2'd0;
                    n.pend  = 1'b0;
                end else if (m.phase == 2'd1 && gap > 0) begin
                    n.phase = 2'd2;
                    n.left  = 16'(gap);
                end else begin
                    nc = nextCh(int'(m.ch), mk);
                    if (nc < 0) begin
                        n.phase = 2'd0;
                        n.pend  = 1'b0;
                    end else begin
                        n.wrap  = (nc <= int'(m.ch));
                        n.ch    = 2'(nc);
                        n.phase = 2'd1;
                        n.left  = 16'(dwell);
                    end
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        if (rst) modValid <= 1'b1;
        mod0 <= stepModel(mod0, rst, start0, stop0, mask0, D0, G0);
        mod1 <= stepModel(mod1, rst, start1, stop1, mask1, D1, G1);
    end

    task automatic checkOutput(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (modValid) begin
            checkOutput("m0.blank", blank0, mod0.phase != 2'd1);
            checkOutput("m0.busy",  busy0,  mod0.phase != 2'd0);
            checkOutput("m0.wrap",  wrap0,  mod0.wrap);
            if (mod0.phase != 2'd0) begin
                checkOutput("m0.a", a0, mod0.ch[0]);
                checkOutput("m0.b", b0, mod0.ch[1]);
            end
            checkOutput("m1.blank", blank1, mod1.phase != 2'd1);
            checkOutput("m1.busy",  busy1,  mod1.phase != 2'd0);
            checkOutput("m1.wrap",  wrap1,  mod1.wrap);
            if (mod1.phase != 2'd0) begin
                checkOutput("m1.a", a1, mod1.ch[0]);
                checkOutput("m1.b", b1, mod1.ch[1]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic st0, input logic sp0, input logic [3:0] m0,
                                 input logic st1, input logic sp1, input logic [3:0] m1);
        start0 = st0; stop0 = sp0; mask0 = m0;
        start1 = st1; stop1 = sp1; mask1 = m1;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((busy0 || busy1) && n < 40) begin
            tick();
            n++;
        end
        checkOutput("idleReached", busy0 | busy1, 1'b0);
    endtask

    initial begin
        int p;
        int c;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 4'b0100);
        tick(); tick();
        rst = 1'b0;

        checkOutput("rst.a", a0, 1'b0);
        checkOutput("rst.b", b0, 1'b0);
        checkOutput("rst.blank", blank0, 1'b1);
        checkOutput("rst.busy", busy0, 1'b0);
        checkOutput("rst.wrap", wrap0, 1'b0);

        // Full mask on dut0 and single channel 2 with no gap on dut1.
        applyStimulus(1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 4'b0100);
        tick();
        start0 = 1'b0; start1 = 1'b0;
        for (int i = 1; i <= 21; i++) begin
            p = (i - 1) % 5;
            c = ((i - 1) / 5) % 4;
            if (p < 4) begin
                checkOutput("full.blank", blank0, 1'b0);
                checkOutput("full.a", a0, c[0]);
                checkOutput("full.b", b0, c[1]);
                checkOutput("full.wrap", wrap0, i == 21);
            end else begin
                checkOutput("full.gap", blank0, 1'b1);
            end
            checkOutput("single.blank", blank1, 1'b0);
            checkOutput("single.a", a1, 1'b0);
            checkOutput("single.b", b1, 1'b1);
            checkOutput("single.wrap", wrap1, i >= 5 && ((i - 1) % 4) == 0);
            tick();
        end
        stop0 = 1'b1; stop1 = 1'b1;
        waitIdle();
        stop0 = 1'b0; stop1 = 1'b0;

        // Alternating channels 1 and 3.
        applyStimulus(1'b1, 1'b0, 4'b1010, 1'b0, 1'b0, 4'b0100);
        tick();
        start0 = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            if (i == 1) begin
                checkOutput("alt1.a", a0, 1'b1); checkOutput("alt1.b", b0, 1'b0);
                checkOutput("alt1.wrap", wrap0, 1'b0);
            end
            if (i == 6) begin
                checkOutput("alt3.a", a0, 1'b1); checkOutput("alt3.b", b0, 1'b1);
                checkOutput("alt3.wrap", wrap0, 1'b0);
            end
            if (i == 11) begin
                checkOutput("alt1w.a", a0, 1'b1); checkOutput("alt1w.b", b0, 1'b0);
                checkOutput("alt1w.wrap", wrap0, 1'b1);
            end
            tick();
        end
        stop0 = 1'b1;
        waitIdle();
        stop0 = 1'b0;

        // Stop pulsed in the second dwell cycle of channel 2.
        applyStimulus(1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 4'b0100);
        tick();
        start0 = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            if (i == 14) begin
                checkOutput("stop.ch2blank", blank0, 1'b0);
                checkOutput("stop.ch2a", a0, 1'b0);
                checkOutput("stop.ch2b", b0, 1'b1);
            end
            if (i == 15) begin
                checkOutput("stop.blank", blank0, 1'b1);
                checkOutput("stop.busy", busy0, 1'b0);
            end
            stop0 = (i == 12);
            tick();
        end
        start0 = 1'b1; stop0 = 1'b1;
        tick();
        checkOutput("stopWins.busy", busy0, 1'b0);
        tick();
        checkOutput("stopWins.blank", blank0, 1'b1);
        start0 = 1'b0; stop0 = 1'b0;

        // Empty mask never starts; clearing the mask stops at the next advance.
        applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'b0100);
        tick();
        checkOutput("noMask.busy", busy0, 1'b0);
        mask0 = 4'hF;
        tick();
        start0 = 1'b0;
        tick(); tick();
        mask0 = 4'h0;
        tick();
        checkOutput("clr.busyC4", busy0, 1'b1);
        checkOutput("clr.blankC4", blank0, 1'b0);
        tick();
        checkOutput("clr.busyC5", busy0, 1'b0);
        checkOutput("clr.blankC5", blank0, 1'b1);

        // Reset during a gap, then restart at the lowest enabled channel.
        applyStimulus(1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 4'b0100);
        tick();
        start0 = 1'b0;
        repeat (4) tick();
        checkOutput("gap.blank", blank0, 1'b1);
        checkOutput("gap.busy", busy0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midRst.a", a0, 1'b0);
        checkOutput("midRst.b", b0, 1'b0);
        checkOutput("midRst.blank", blank0, 1'b1);
        checkOutput("midRst.busy", busy0, 1'b0);
        checkOutput("midRst.wrap", wrap0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'b0110, 1'b0, 1'b0, 4'b0100);
        tick();
        start0 = 1'b0;
        checkOutput("restart.busy", busy0, 1'b1);
        checkOutput("restart.a", a0, 1'b1);
        checkOutput("restart.b", b0, 1'b0);
        checkOutput("restart.wrap", wrap0, 1'b0);
        stop0 = 1'b1;
        waitIdle();
        stop0 = 1'b0;

        // Randomised traffic, checked by the continuous model comparison.
        for (int i = 0; i < 3000; i++) begin
            start0 = ($urandom_range(0, 3) == 0);
            stop0  = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 29) == 0) mask0 = 4'($urandom_range(0, 15));
            start1 = ($urandom_range(0, 3) == 0);
            stop1  = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 29) == 0) mask1 = 4'($urandom_range(0, 15));
            rst    = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
